// File: rtl/selfcomp_leak_monitor_if.sv
// Stimulus/response bundle shared by N self-composed DUT copies and the leak monitor.
// The master side belongs to whoever drives the copies; the monitor observes through the slave side.
interface selfcomp_leak_monitor_if #(
    parameter int NUM_COPIES = 2,
    parameter int DATA_W     = 128
);
    logic                         in_fire;
    logic [NUM_COPIES-1:0]        out_valid;
    logic [NUM_COPIES*DATA_W-1:0] out_result;

    modport master (output in_fire, output out_valid, output out_result);
    modport slave  (input  in_fire, input  out_valid, input  out_result);
endinterface

// File: rtl/selfcomp_leak_monitor.sv
// Self-composition checker: watches N identical DUT copies for completion skew, timeouts and result divergence.
// Optional macro SELFCOMP_DATA_CHECK_EN adds result capture and the dataLeak comparison.
module selfcomp_leak_monitor #(
    parameter int NUM_COPIES = 2,
    parameter int DATA_W     = 128,
    parameter int CNT_W      = 8,
    parameter int MAX_SKEW   = 0,
    parameter int TIMEOUT    = 200
) (
    input  logic                        clock,
    input  logic                        reset,
    selfcomp_leak_monitor_if.slave      mon,
    input  logic                        clear,
    output logic                        busy,
    output logic                        allValid,
    output logic                        anyValid,
    output logic                        timingLeak,
    output logic                        dataLeak,
    output logic                        timingLeakDone,
    output logic [NUM_COPIES*CNT_W-1:0] latency,
    output logic [CNT_W-1:0]            maxSkew,
    output logic                        overlapErr
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [NUM_COPIES-1:0]   done_q;
    logic [CNT_W-1:0]        lat_q [NUM_COPIES];
    logic [CNT_W-1:0]        skew_q;
    logic [WAIT_W-1:0]       wait_q;

    logic [NUM_COPIES-1:0]   done_next;
    logic                    all_done_next;
    logic [WAIT_W-1:0]       wait_next;
    logic                    timeout_hit;
    logic                    close_ok;
    logic                    close_to;
    logic                    start;
    logic                    overlap_set;

    assign allValid = &mon.out_valid;
    assign anyValid = |mon.out_valid;

    // A copy counts as done in the cycle its first valid arrives, so closing uses done_next.
    assign done_next     = done_q | mon.out_valid;
    assign all_done_next = &done_next;
    assign wait_next     = wait_q + WAIT_W'(1);
    assign timeout_hit   = (wait_next == WAIT_W'(TIMEOUT));
    assign close_ok      = (state_q == ST_WAIT) && all_done_next;
    assign close_to      = (state_q == ST_WAIT) && !all_done_next && timeout_hit;
    assign start         = mon.in_fire && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign overlap_set   = mon.in_fire && ((state_q == ST_WAIT) || (state_q == ST_CHECK));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        busy           = 1'b0;
        timingLeakDone = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mon.in_fire) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (all_done_next || timeout_hit) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                busy    = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                timingLeakDone = 1'b1;
                state_d        = mon.in_fire ? ST_WAIT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Skew runs from the first completion until the last one, so it is not bumped on the closing cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            done_q  <= '0;
            skew_q  <= '0;
            wait_q  <= '0;
            latency <= '0;
            for (int i = 0; i < NUM_COPIES; i++) lat_q[i] <= '0;
        end else begin
            if (start) begin
                done_q <= '0;
                skew_q <= '0;
                wait_q <= '0;
                for (int i = 0; i < NUM_COPIES; i++) lat_q[i] <= '0;
            end else if (state_q == ST_WAIT) begin
                wait_q <= wait_next;
                done_q <= done_next;
                for (int i = 0; i < NUM_COPIES; i++) begin
                    if (!done_q[i]) begin
                        if (close_to && !mon.out_valid[i]) begin
                            lat_q[i] <= CNT_MAX;
                        end else if (lat_q[i] != CNT_MAX) begin
                            lat_q[i] <= lat_q[i] + CNT_W'(1);
                        end
                    end
                end
                if ((|done_next) && !all_done_next && (skew_q != CNT_MAX)) begin
                    skew_q <= skew_q + CNT_W'(1);
                end
            end
            if (state_q == ST_CHECK) begin
                for (int i = 0; i < NUM_COPIES; i++) latency[i*CNT_W +: CNT_W] <= lat_q[i];
            end
        end
    end

    // Sticky flags: a set event in the same cycle as clear takes priority.
    always_ff @(posedge clock) begin
        if (!reset) begin
            timingLeak <= 1'b0;
            overlapErr <= 1'b0;
            maxSkew    <= '0;
        end else begin
            if (clear) begin
                timingLeak <= 1'b0;
                overlapErr <= 1'b0;
                maxSkew    <= '0;
            end
            if (close_to || (close_ok && (skew_q > CNT_W'(MAX_SKEW)))) timingLeak <= 1'b1;
            if (close_ok && (clear || (skew_q > maxSkew))) maxSkew <= skew_q;
            if (overlap_set) overlapErr <= 1'b1;
        end
    end

`ifdef SELFCOMP_DATA_CHECK_EN
    logic [DATA_W-1:0] cap_q [NUM_COPIES];
    logic              mismatch;

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_COPIES; i++) cap_q[i] <= '0;
        end else if (state_q == ST_WAIT) begin
            for (int i = 0; i < NUM_COPIES; i++) begin
                if (mon.out_valid[i] && !done_q[i]) cap_q[i] <= mon.out_result[i*DATA_W +: DATA_W];
            end
        end
    end

    // Copies that never completed have no meaningful capture and are left out of the comparison.
    always_comb begin
        mismatch = 1'b0;
        for (int i = 1; i < NUM_COPIES; i++) begin
            if (done_q[0] && done_q[i] && (cap_q[i] != cap_q[0])) mismatch = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            dataLeak <= 1'b0;
        end else begin
            if (clear) dataLeak <= 1'b0;
            if ((state_q == ST_CHECK) && mismatch) dataLeak <= 1'b1;
        end
    end
`else
    logic unused_result;
    assign unused_result = ^mon.out_result;
    assign dataLeak      = 1'b0;
`endif

endmodule

// File: tb/tb_selfcomp_leak_monitor.sv
// Directed plus randomized bench for selfcomp_leak_monitor with four copies, checked against a per-transaction arrival model.
module tb_selfcomp_leak_monitor;

    localparam int NC = 4;
    localparam int DW = 32;
    localparam int CW = 8;
    localparam int MS = 1;
    localparam int TO = 12;
`ifdef SELFCOMP_DATA_CHECK_EN
    localparam bit DATA_EN = 1'b1;
`else
    localparam bit DATA_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic clear = 1'b0;
    logic busy, allValid, anyValid, timingLeak, dataLeak, timingLeakDone, overlapErr;
    logic [NC*CW-1:0] latency;
    logic [CW-1:0]    maxSkew;

    always #5 clock = ~clock;

    selfcomp_leak_monitor_if #(.NUM_COPIES(NC), .DATA_W(DW)) bus ();

    selfcomp_leak_monitor #(
        .NUM_COPIES(NC), .DATA_W(DW), .CNT_W(CW), .MAX_SKEW(MS), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset), .mon(bus), .clear(clear),
        .busy(busy), .allValid(allValid), .anyValid(anyValid),
        .timingLeak(timingLeak), .dataLeak(dataLeak), .timingLeakDone(timingLeakDone),
        .latency(latency), .maxSkew(maxSkew), .overlapErr(overlapErr)
    );

    int vectors = 0;
    int miscompares = 0;

    // Per-transaction stimulus: first-valid cycle of each copy (0 = never) and its result.
    int          td [NC];
    logic [DW-1:0] tres [NC];

    // Reference state kept at the level of "what the monitor should have concluded so far".
    bit m_timing, m_data, m_overlap;
    int m_maxskew;
    int m_lat [NC];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] expLatency();
        logic [63:0] r = '0;
        for (int i = 0; i < NC; i++) r[i*CW +: CW] = m_lat[i][CW-1:0];
        return r;
    endfunction

    task automatic modelReset();
        m_timing = 0; m_data = 0; m_overlap = 0; m_maxskew = 0;
        for (int i = 0; i < NC; i++) m_lat[i] = 0;
    endtask

    task automatic modelClear();
        m_timing = 0; m_data = 0; m_overlap = 0; m_maxskew = 0;
    endtask

    task automatic checkFlags(input string where);
        checkOutput({where, ".timingLeak"}, timingLeak, m_timing);
        checkOutput({where, ".dataLeak"},   dataLeak,   m_data);
        checkOutput({where, ".overlapErr"}, overlapErr, m_overlap);
        checkOutput({where, ".maxSkew"},    maxSkew,    m_maxskew);
        checkOutput({where, ".latency"},    latency,    expLatency());
    endtask

    task automatic idleCycle(input bit do_clear);
        bus.in_fire = 0; bus.out_valid = '0; clear = do_clear;
        @(negedge clock);
        checkOutput("idle.busy", busy, 0);
        checkOutput("idle.done", timingLeakDone, 0);
        checkFlags("idle");
        @(posedge clock);
        if (do_clear) modelClear();
        #1 clear = 0;
    endtask

    // One transaction from fire to DONE; entered and left 1 time unit after a rising edge.
    task automatic applyStimulus(input bit skip_fire, input bit chain_next, input bit noisy);
        bit all_ok, to_hit, mism;
        bit done_e [NC];
        int lat_e [NC];
        int mx, mn, end_k, skew;
        logic [NC-1:0] v;

        all_ok = 1; mx = 0; mn = 1000;
        for (int i = 0; i < NC; i++) begin
            if (td[i] == 0 || td[i] > TO) all_ok = 0;
            else begin
                if (td[i] > mx) mx = td[i];
                if (td[i] < mn) mn = td[i];
            end
        end
        to_hit = !all_ok;
        end_k  = all_ok ? mx : TO;
        skew   = mx - mn;
        for (int i = 0; i < NC; i++) begin
            done_e[i] = (td[i] != 0) && (td[i] <= end_k);
            lat_e[i]  = done_e[i] ? td[i] : 255;
        end
        mism = 0;
        for (int i = 1; i < NC; i++)
            if (DATA_EN && done_e[0] && done_e[i] && tres[i] != tres[0]) mism = 1;

        if (!skip_fire) begin
            bus.in_fire = 1; bus.out_valid = '0; clear = 0;
            @(negedge clock);
            checkOutput("fire.busy", busy, 0);
            @(posedge clock);
            #1;
        end
        for (int k = 1; k <= end_k + 1; k++) begin
            bus.in_fire = noisy && ($urandom_range(0, 5) == 0);
            clear       = noisy && ($urandom_range(0, 5) == 0);
            for (int i = 0; i < NC; i++) begin
                v[i] = (k == td[i]) || (td[i] != 0 && k > td[i] && noisy && ($urandom_range(0, 1) == 1));
                bus.out_result[i*DW +: DW] = (k == td[i]) ? tres[i] : DW'($urandom);
            end
            bus.out_valid = v;
            @(negedge clock);
            checkOutput("wait.anyValid", anyValid, |v);
            checkOutput("wait.allValid", allValid, &v);
            checkOutput("wait.busy", busy, 1);
            checkOutput("wait.done", timingLeakDone, 0);
            checkFlags("wait");
            @(posedge clock);
            if (clear) modelClear();
            if (k == end_k) begin
                if (to_hit || skew > MS) m_timing = 1;
                if (!to_hit && skew > m_maxskew) m_maxskew = skew;
            end
            if (k == end_k + 1) begin
                if (mism) m_data = 1;
                for (int i = 0; i < NC; i++) m_lat[i] = lat_e[i];
            end
            if (bus.in_fire) m_overlap = 1;
            #1;
        end
        bus.in_fire = chain_next; clear = 0; bus.out_valid = '0;
        @(negedge clock);
        checkOutput("done.pulse", timingLeakDone, 1);
        checkOutput("done.busy", busy, 0);
        checkFlags("done");
        @(posedge clock);
        #1 bus.in_fire = 0;
    endtask

    task automatic setTxn(input int d0, d1, d2, d3, input logic [DW-1:0] r0, r1, r2, r3);
        td[0] = d0; td[1] = d1; td[2] = d2; td[3] = d3;
        tres[0] = r0; tres[1] = r1; tres[2] = r2; tres[3] = r3;
    endtask

    initial begin
        bit chain, prev_chain;
        int base;
        logic [DW-1:0] common;

        bus.in_fire = 0; bus.out_valid = '0; bus.out_result = '0;
        modelReset();

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.done", timingLeakDone, 0);
        checkOutput("reset.allValid", allValid, 0);
        checkFlags("reset");
        reset = 1;
        @(posedge clock);
        #1;

        // Equal completion at cycle 5
        setTxn(5, 5, 5, 5, 32'hA5, 32'hA5, 32'hA5, 32'hA5);
        applyStimulus(0, 0, 0);
        idleCycle(0);

        // Skew of 3 exceeds the window; clear then drops flags but keeps latency
        setTxn(3, 6, 3, 3, 32'h7, 32'h7, 32'h7, 32'h7);
        applyStimulus(0, 0, 0);
        idleCycle(1);
        idleCycle(0);

        // Same timing, diverging results
        setTxn(4, 4, 4, 4, 32'h1, 32'h2, 32'h1, 32'h1);
        applyStimulus(0, 0, 0);
        idleCycle(1);

        // Only copy 0 completes: timeout, others saturate
        setTxn(2, 0, 0, 0, 32'h9, 32'h9, 32'h9, 32'h9);
        applyStimulus(0, 0, 0);
        idleCycle(1);

        // Skew exactly at the allowed window
        setTxn(2, 2, 3, 2, 32'h3, 32'h3, 32'h3, 32'h3);
        applyStimulus(0, 0, 0);
        idleCycle(0);

        // Fire while in DONE starts a new transaction without an overlap error
        setTxn(3, 1, 2, 3, 32'h4, 32'h4, 32'h4, 32'h4);
        applyStimulus(0, 1, 0);
        setTxn(1, 1, 1, 1, 32'h5, 32'h5, 32'h5, 32'h5);
        applyStimulus(1, 0, 0);
        idleCycle(1);

        // Overlapping fire, then reset mid-transaction
        bus.in_fire = 1;
        @(posedge clock);
        #1 bus.in_fire = 0;
        @(posedge clock);
        #1 bus.in_fire = 1;
        @(posedge clock);
        m_overlap = 1;
        #1 bus.in_fire = 0;
        @(negedge clock);
        checkOutput("overlap.flag", overlapErr, 1);
        checkOutput("overlap.busy", busy, 1);
        reset = 0;
        @(posedge clock);
        modelReset();
        #1;
        @(negedge clock);
        checkOutput("midreset.busy", busy, 0);
        checkOutput("midreset.done", timingLeakDone, 0);
        checkFlags("midreset");
        reset = 1;
        @(posedge clock);
        #1;
        repeat (4) idleCycle(0);

        // Randomized transactions with noise, overlap fires, clears and chaining
        prev_chain = 0;
        for (int n = 0; n < 40; n++) begin
            base   = $urandom_range(1, 8);
            common = DW'($urandom);
            for (int i = 0; i < NC; i++) begin
                td[i]   = ($urandom_range(0, 11) == 0) ? 0 : base + $urandom_range(0, 3);
                tres[i] = ($urandom_range(0, 5) == 0) ? DW'($urandom) : common;
            end
            chain = (n != 39) && ($urandom_range(0, 2) == 0);
            applyStimulus(prev_chain, chain, 1);
            if (!chain) idleCycle($urandom_range(0, 2) == 0);
            prev_chain = chain;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/selfcomp_leak_monitor.md
Name: selfcomp_leak_monitor

Overview:
- Parametrised self-composition checker for N identical DUT copies (e.g. SE instances) driven by the same input stream.
- Per transaction, tracks each copy's response latency and captured result.
- Flags timing leaks (completion skew beyond a window, or timeout) and data divergence.
- Reports a one-cycle done pulse per checked transaction; the leak flags are sticky.

Parameters:
- NUM_COPIES, 2, number of DUT copies monitored (2..8).
- DATA_W, 128, width of each copy's result.
- CNT_W, 8, width of latency counters and of the io_out_cntr-style latency outputs.
- MAX_SKEW, 0, allowed cycles between the first and last copy completing.
- TIMEOUT, 200, cycles in WAIT before the transaction is forced closed.

Ports:
- clock, in, 1, sole clock; all logic on rising edge.
- reset, in, 1, synchronous active-low reset (0 = reset), sampled on rising clock.
- in_fire, in, 1, pulse: request accepted by the copies (io_in_valid & io_in_ready).
- out_valid, in, NUM_COPIES, bit i = copy i result valid.
- out_result, in, NUM_COPIES*DATA_W, copy i result at bits [i*DATA_W +: DATA_W].
- clear, in, 1, synchronous clear of the sticky flags and counters.
- busy, out, 1, high in WAIT or CHECK.
- allValid, out, 1, AND of out_valid (combinational).
- anyValid, out, 1, OR of out_valid (combinational).
- timingLeak, out, 1, sticky: skew or timeout violation seen.
- dataLeak, out, 1, sticky: result mismatch seen.
- timingLeakDone, out, 1, one-cycle pulse when a transaction's check completes.
- latency, out, NUM_COPIES*CNT_W, last completed per-copy latency.
- maxSkew, out, CNT_W, largest skew observed since reset/clear.
- overlapErr, out, 1, sticky: in_fire arrived while busy.

Behaviour:
- Reset (reset=0): FSM=IDLE; every registered output and internal register cleared to 0. Reset overrides all other inputs, including mid-transaction; the partial transaction is discarded and no done pulse is produced.
- clear=1 (reset=1): zeroes timingLeak, dataLeak, overlapErr and maxSkew. It does not disturb the FSM or the latency outputs. If clear and a flag-set event occur in the same cycle, the set wins.
- FSM states: IDLE, WAIT, CHECK, DONE.
- IDLE: on in_fire go to WAIT. In the same edge, clear the per-copy done bits, latency counters, skew counter and wait counter.
- WAIT, per copy i:
  - While done[i]=0, lat[i] increments each cycle (saturating at 2^CNT_W-1).
  - On the first cycle out_valid[i]=1: set done[i], freeze lat[i] and capture out_result[i].
  - Later valid cycles of a done copy are ignored.
  - Latency counts the first WAIT cycle as 1. A copy valid in that cycle therefore reports lat=1.
- Skew counter: starts on the cycle the first done bit sets and increments each cycle while not all copies are done. Copies completing in the same cycle contribute skew 0.
- WAIT to CHECK when all done bits are set, counting bits set that cycle.
- Skew check on WAIT to CHECK:
  - skew > MAX_SKEW sets timingLeak.
  - maxSkew = max(maxSkew, skew).
- Timeout: wait counter reaches TIMEOUT with not all copies done. Set timingLeak and go to CHECK; undone copies report lat = saturated value.
- CHECK (1 cycle): compare each captured result with copy 0's; any difference among done copies sets dataLeak. Copy latency counters to the latency output, then go to DONE.
- DONE (1 cycle): timingLeakDone=1, then go to IDLE. in_fire in DONE is accepted as a new transaction (go to WAIT directly); it is not an overlap.
- in_fire during WAIT or CHECK is ignored and sets overlapErr.
- busy = (state==WAIT || state==CHECK).
- Latency from last copy valid to timingLeakDone: 2 cycles (CHECK, then DONE).

Optional Feature:
- Macro SELFCOMP_DATA_CHECK_EN.
- Defined: result capture registers and the CHECK comparison exist, and dataLeak behaves as above.
- Undefined: no capture registers; dataLeak is tied 0; CHECK still takes 1 cycle so timing is unchanged.

Test Plan:
- NUM_COPIES=2, in_fire at t0, both out_valid at t0+5, equal results 0xA5 -> latency={5,5}, timingLeak=0, dataLeak=0, timingLeakDone pulse at t0+7.
- Copy0 valid at t0+3, copy1 at t0+6, MAX_SKEW=0 -> timingLeak=1, maxSkew=3, latency={3,6}; clear=1 then -> timingLeak=0, maxSkew=0.
- Both valid at t0+4, results 0x1 vs 0x2 -> dataLeak=1, timingLeak=0; with SELFCOMP_DATA_CHECK_EN undefined -> dataLeak=0.
- TIMEOUT=10, only copy0 valid at t0+2 -> at t0+10 timingLeak=1, latency={2,255}, timingLeakDone follows 2 cycles later.
- in_fire again at t0+2 during WAIT -> overlapErr=1, transaction unaffected; reset=0 at t0+3 -> all outputs 0, FSM IDLE, no done pulse.
- NUM_COPIES=4, copies valid at +2,+2,+3,+2 with MAX_SKEW=1 -> timingLeak=0, maxSkew=1, allValid=1 only while all four valid are high.
